n64_poll_scheduler: RTL and testbench

Sequences the single-wire N64 link: every poll interval it commands the line encoder to transmit the 8-bit poll command 0x01, then hands the line to the bit decoder and collects the 32-bit controller response. It latches the 12 button bits into the top-level output and tracks link health, with a response timeout and a bounded retry count. It sits between the divided-clock domain (clk_slow) and the encoder/decoder pair, replacing the ad-hoc enable wiring between them.

---
 rtl/n64_pkg.sv | 23 ++
 rtl/n64_resp_shifter.sv | 31 +++
 rtl/n64_poll_scheduler.sv | 154 +++++++++++++++
 tb/tb_n64_poll_scheduler.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/n64_pkg.sv
// Shared types and constants for the N64 controller poll scheduler.
package n64_pkg;

  typedef enum logic [2:0] {IDLE, SEND, WAIT_TX, RECV, FAIL} poll_state_t;

  localparam logic [7:0] N64_CMD_POLL  = 8'h01;
  localparam int         N64_RESP_BITS = 32;

  // Bit positions inside btn_out = {A,B,Z,Start,DU,DD,DL,DR,L,R,CU,CD}
  localparam int BTN_A     = 11;
  localparam int BTN_B     = 10;
  localparam int BTN_Z     = 9;
  localparam int BTN_START = 8;
  localparam int BTN_DU    = 7;
  localparam int BTN_DD    = 6;
  localparam int BTN_DL    = 5;
  localparam int BTN_DR    = 4;
  localparam int BTN_L     = 3;
  localparam int BTN_R     = 2;
  localparam int BTN_CU    = 1;
  localparam int BTN_CD    = 0;

endpackage

// File: rtl/n64_resp_shifter.sv
// MSB-first response shift register with bit counter; full once NBITS bits are in.
module n64_resp_shifter
  import n64_pkg::*;
#(
  parameter int NBITS = N64_RESP_BITS
) (
  input  logic                     clk,
  input  logic                     Reset,
  input  logic                     clear,
  input  logic                     shift,
  input  logic                     shift_bit,
  output logic [N64_RESP_BITS-1:0] sr,
  output logic [5:0]               count,
  output logic                     full
);

  always_ff @(posedge clk) begin
    if (!Reset) begin
      sr    <= '0;
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (shift) begin
      sr    <= {sr[N64_RESP_BITS-2:0], shift_bit};
      count <= count + 6'd1;
    end
  end

  assign full = (count == 6'(NBITS));

endmodule

// File: rtl/n64_poll_scheduler.sv
// N64 link poll sequencer: periodic poll command, response capture, timeout/retry health.
// Optional N64_STICK_OUT_EN adds the stick_x/stick_y analog outputs.
//
// state   | meaning
// IDLE    | waiting for the poll period to expire
// SEND    | one-cycle tx_start to the encoder
// WAIT_TX | waiting for encoder tx_done (no timeout)
// RECV    | decoder enabled, collecting response bits
// FAIL    | response timed out; bump retry count
module n64_poll_scheduler
  import n64_pkg::*;
#(
  parameter int POLL_PERIOD  = 14583,
  parameter int RESP_BITS    = 32,
  parameter int RESP_TIMEOUT = 64,
  parameter int MAX_RETRY    = 3
) (
  input  logic        clk,
  input  logic        Reset,
  output logic        tx_start,
  output logic [7:0]  tx_cmd,
  input  logic        tx_done,
  output logic        rx_en,
  input  logic        rx_bit_valid,
  input  logic        rx_bit,
  output logic [11:0] btn_out,
  output logic        frame_valid,
  output logic        link_up,
  output logic        err_timeout
`ifdef N64_STICK_OUT_EN
  ,
  output logic [7:0]  stick_x,
  output logic [7:0]  stick_y
`endif
);

  localparam int PW = $clog2(POLL_PERIOD);
  localparam int TW = $clog2(RESP_TIMEOUT);
  localparam int RW = $clog2(MAX_RETRY + 1);

  localparam logic [2:0] ST_IDLE    = 3'(IDLE);
  localparam logic [2:0] ST_SEND    = 3'(SEND);
  localparam logic [2:0] ST_WAIT_TX = 3'(WAIT_TX);
  localparam logic [2:0] ST_RECV    = 3'(RECV);
  localparam logic [2:0] ST_FAIL    = 3'(FAIL);

  logic [2:0]               state;
  logic [PW-1:0]            period_cnt;
  logic [TW-1:0]            timer;
  logic [RW-1:0]            retry;
  logic [N64_RESP_BITS-1:0] sr;
  logic [5:0]               bit_count;
  logic                     full;
  logic                     period_hit;
  logic                     sh_clear;
  logic                     sh_shift;

  assign period_hit = (period_cnt == PW'(POLL_PERIOD - 1));
  assign sh_clear   = (state == ST_WAIT_TX) && tx_done;
  assign sh_shift   = (state == ST_RECV) && rx_bit_valid && !full;

  n64_resp_shifter #(
    .NBITS(RESP_BITS)
  ) u_shifter (
    .clk      (clk),
    .Reset    (Reset),
    .clear    (sh_clear),
    .shift    (sh_shift),
    .shift_bit(rx_bit),
    .sr       (sr),
    .count    (bit_count),
    .full     (full)
  );

  // The period counter free-runs in every state so the poll rate never drifts.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      state       <= ST_IDLE;
      period_cnt  <= '0;
      timer       <= '0;
      retry       <= '0;
      btn_out     <= '0;
      frame_valid <= 1'b0;
      link_up     <= 1'b0;
`ifdef N64_STICK_OUT_EN
      stick_x     <= '0;
      stick_y     <= '0;
`endif
    end else begin
      frame_valid <= 1'b0;
      if (period_hit) period_cnt <= '0;
      else            period_cnt <= period_cnt + PW'(1);

      case (state)
        ST_IDLE:    if (period_hit) state <= ST_SEND;
        ST_SEND:    state <= ST_WAIT_TX;
        ST_WAIT_TX: begin
          if (tx_done) begin
            state <= ST_RECV;
            timer <= '0;
          end
        end
        ST_RECV: begin
          if (full) begin
            btn_out     <= {sr[31:24], sr[21:18]};
`ifdef N64_STICK_OUT_EN
            stick_x     <= sr[15:8];
            stick_y     <= sr[7:0];
`endif
            frame_valid <= 1'b1;
            link_up     <= 1'b1;
            retry       <= '0;
            state       <= ST_IDLE;
          end else if (rx_bit_valid) begin
            timer <= '0;
          end else if (timer == TW'(RESP_TIMEOUT - 1)) begin
            state <= ST_FAIL;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ST_FAIL: begin
          state <= ST_IDLE;
          if (retry >= RW'(MAX_RETRY - 1)) begin
            retry   <= RW'(MAX_RETRY);
            link_up <= 1'b0;
            btn_out <= '0;
`ifdef N64_STICK_OUT_EN
            stick_x <= '0;
            stick_y <= '0;
`endif
          end else begin
            retry <= retry + RW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign tx_start    = (state == ST_SEND);
  assign rx_en       = (state == ST_RECV);
  assign err_timeout = (state == ST_FAIL);
  assign tx_cmd      = N64_CMD_POLL;

  // Response bits that carry no output in this build.
  logic unused_bits;
`ifdef N64_STICK_OUT_EN
  assign unused_bits = ^{sr[23:22], sr[17:16], bit_count};
`else
  assign unused_bits = ^{sr[23:22], sr[17:0], bit_count};
`endif

endmodule

// File: tb/tb_n64_poll_scheduler.sv
// Randomized bench for n64_poll_scheduler against a transaction-level poll outcome model.
module tb_n64_poll_scheduler;

  localparam int P  = 100;
  localparam int T  = 64;
  localparam int MR = 3;

  logic        clk = 1'b0;
  logic        Reset = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_cmd;
  logic        tx_done = 1'b0;
  logic        rx_en;
  logic        rx_bit_valid = 1'b0;
  logic        rx_bit = 1'b0;
  logic [11:0] btn_out;
  logic        frame_valid;
  logic        link_up;
  logic        err_timeout;
`ifdef N64_STICK_OUT_EN
  logic [7:0]  stick_x;
  logic [7:0]  stick_y;
`endif

  always #5 clk = ~clk;

  n64_poll_scheduler #(
    .POLL_PERIOD (P),
    .RESP_BITS   (32),
    .RESP_TIMEOUT(T),
    .MAX_RETRY   (MR)
  ) dut (
    .clk         (clk),
    .Reset       (Reset),
    .tx_start    (tx_start),
    .tx_cmd      (tx_cmd),
    .tx_done     (tx_done),
    .rx_en       (rx_en),
    .rx_bit_valid(rx_bit_valid),
    .rx_bit      (rx_bit),
    .btn_out     (btn_out),
    .frame_valid (frame_valid),
    .link_up     (link_up),
    .err_timeout (err_timeout)
`ifdef N64_STICK_OUT_EN
    ,
    .stick_x     (stick_x),
    .stick_y     (stick_y)
`endif
  );

  // cyc = number of clock edges since reset release
  int cyc = 0;
  always @(posedge clk) begin
    if (!Reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int n_start = 0, n_frame = 0, n_err = 0;
  always @(negedge clk) begin
    if (tx_start)    n_start <= n_start + 1;
    if (frame_valid) n_frame <= n_frame + 1;
    if (err_timeout) n_err   <= n_err + 1;
  end

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model state
  int          exp_fails  = 0;
  logic        exp_link   = 1'b0;
  logic [11:0] exp_btn    = '0;
  logic [7:0]  exp_sx     = '0;
  logic [7:0]  exp_sy     = '0;
  int          next_start = P;
  int          exp_starts = 0;
  int          exp_frames = 0;
  int          exp_errs   = 0;

  function automatic int next_mult(input int x);
    return ((x + P - 1) / P) * P;
  endfunction

  task automatic chk_held();
    chk("btn_out", btn_out, exp_btn);
    chk("link_up", link_up, exp_link);
`ifdef N64_STICK_OUT_EN
    chk("stick_x", stick_x, exp_sx);
    chk("stick_y", stick_y, exp_sy);
`endif
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_rx_en"}, rx_en, 0);
    chk({tag, "_frame_valid"}, frame_valid, 0);
    chk({tag, "_err"}, err_timeout, 0);
    chk({tag, "_link"}, link_up, 0);
    chk({tag, "_btn"}, btn_out, 0);
    chk({tag, "_tx_cmd"}, tx_cmd, 8'h01);
`ifdef N64_STICK_OUT_EN
    chk({tag, "_sx"}, stick_x, 0);
    chk({tag, "_sy"}, stick_y, 0);
`endif
  endtask

  // One poll: nbits response bits of data; coinc = bit index sent on the timer expiry cycle;
  // abort = apply reset after nbits bits instead of waiting for an outcome.
  task automatic run_poll(input int txd, input int nbits, input logic [31:0] data,
                          input int coinc, input bit abort);
    int w;
    int last;
    int got_cyc;
    logic got_frame, got_err;
    w = 0;
    while (!tx_start && w < 3 * P) begin step(); w++; end
    chk("start_seen", tx_start, 1);
    chk("start_cyc", cyc, next_start);
    exp_starts++;
    step();
    chk("start_one_cycle", tx_start, 0);
    chk("start_count", n_start, exp_starts);
    for (int i = 1; i < txd; i++) step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    last = cyc;
    chk("rx_en_recv", rx_en, 1);
    for (int i = 0; i < nbits; i++) begin
      int g;
      g = (i == coinc) ? T - 1 : int'($urandom_range(0, 3));
      for (int k = 0; k < g; k++) begin rx_bit = 1'($urandom); step(); end
      rx_bit_valid = 1'b1;
      rx_bit = data[31-i];
      step();
      last = cyc;
      rx_bit_valid = 1'b0;
      rx_bit = 1'($urandom);
    end
    if (abort) begin
      Reset = 1'b0;
      step();
      chk_idle_zero("rst");
      Reset = 1'b1;
      rx_bit_valid = 1'b1;
      rx_bit = 1'b1;
      tx_done = 1'b1;
      step();
      rx_bit_valid = 1'b0;
      tx_done = 1'b0;
      chk_idle_zero("post_rst");
      exp_fails = 0; exp_link = 1'b0; exp_btn = '0; exp_sx = '0; exp_sy = '0;
      next_start = P;
      return;
    end
    w = 0;
    while (!(frame_valid || err_timeout) && w < 2 * T) begin step(); w++; end
    got_frame = frame_valid;
    got_err   = err_timeout;
    got_cyc   = cyc;
    if (nbits == 32) begin
      exp_frames++;
      exp_fails = 0;
      exp_link  = 1'b1;
      exp_btn   = {data[31:24], data[21:18]};
      exp_sx    = data[15:8];
      exp_sy    = data[7:0];
      chk("frame_seen", got_frame, 1);
      chk("frame_cyc", got_cyc, last + 1);
      chk("no_err", got_err, 0);
      chk("rx_en_drop", rx_en, 0);
      chk_held();
      next_start = next_mult(got_cyc + 1);
    end else begin
      exp_errs++;
      exp_fails = (exp_fails + 1 > MR) ? MR : exp_fails + 1;
      if (exp_fails == MR) begin
        exp_link = 1'b0; exp_btn = '0; exp_sx = '0; exp_sy = '0;
      end
      chk("err_seen", got_err, 1);
      chk("err_cyc", got_cyc, last + T);
      chk("no_frame", got_frame, 0);
      next_start = next_mult(got_cyc + 2);
    end
    step();
    chk("pulse_end_fv", frame_valid, 0);
    chk("pulse_end_err", err_timeout, 0);
    chk("rx_en_idle", rx_en, 0);
    chk_held();
  endtask

  initial begin
    logic [31:0] d;
    repeat (3) step();
    chk_idle_zero("reset");
    Reset = 1'b1;

    run_poll(20, 32, 32'h9020_7F81, -1, 1'b0);
    for (int i = 0; i < 3; i++) run_poll(5, 0, 32'h0, -1, 1'b0);
    chk("link_lost", link_up, 0);
    d = $urandom;
    run_poll(7, 32, d, -1, 1'b0);
    chk("link_back", link_up, 1);
    run_poll(3, 10, 32'hFFFF_FFFF, -1, 1'b0);
    chk("stall_link_kept", link_up, 1);
    run_poll(4, 32, $urandom, 17, 1'b0);
    run_poll(2, 32, $urandom, 0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      bit good;
      good = ($urandom_range(0, 3) != 0);
      run_poll(int'($urandom_range(1, 30)), good ? 32 : int'($urandom_range(0, 31)),
               $urandom, -1, 1'b0);
    end
    run_poll(2 * P + 5, 32, $urandom, -1, 1'b0);
    run_poll(10, 16, $urandom, -1, 1'b1);
    run_poll(6, 32, $urandom, -1, 1'b0);

    chk("total_starts", n_start, exp_starts);
    chk("total_frames", n_frame, exp_frames);
    chk("total_errs", n_err, exp_errs);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
